// File: rtl/pipe_link_if.sv
// Bus bundle for pipe_link: write/read handshakes, flush and status.
// The master side drives requests; the slave side is the FIFO itself.
interface pipe_link_if #(
  parameter int DATA_L = 64,
  parameter int ADDR_L = 4
);
  logic              flush;
  logic              we;
  logic [DATA_L-1:0] din;
  logic              full;
  logic              afull;
  logic              re;
  logic [DATA_L-1:0] dout;
  logic              av;
  logic [ADDR_L:0]   cnt;
  logic              ovf;

  modport master (output flush, we, din, re,
                  input  full, afull, dout, av, cnt, ovf);
  modport slave  (input  flush, we, din, re,
                  output full, afull, dout, av, cnt, ovf);
endinterface

// File: rtl/pipe_link.sv
// Inter-stage FWFT FIFO with flush, almost-full look-ahead and a sticky error flag.
// Define PIPE_LINK_BYPASS_EN to let a write into an empty FIFO appear at dout in the same cycle.
module pipe_link #(
  parameter int DATA_L   = 64,
  parameter int ADDR_L   = 4,
  parameter int AFULL_TH = 2
) (
  input logic       clk,
  input logic       rst,
  pipe_link_if.slave bus
);
  localparam int              DEPTH   = 1 << ADDR_L;
  localparam logic [ADDR_L:0] DEPTH_C = DEPTH[ADDR_L:0];

  logic [DATA_L-1:0] mem [DEPTH];
  logic [ADDR_L-1:0] wptr, rptr;
  logic [ADDR_L:0]   cnt, free;
  logic              ovf;
  logic              empty, full, av, byp, pop, do_wr, do_rd, drop, under;

  always_comb begin
    empty = (cnt == '0);
    full  = (cnt == DEPTH_C);
    free  = DEPTH_C - cnt;
`ifdef PIPE_LINK_BYPASS_EN
    byp   = empty & ~bus.flush & bus.we;
`else
    byp   = 1'b0;
`endif
    av    = ~empty | byp;
    pop   = bus.re & av;
    // A bypassed word that is popped at once never touches storage.
    do_wr = bus.we & (~full | pop) & ~(byp & bus.re) & ~bus.flush;
    do_rd = pop & ~byp & ~bus.flush;
    drop  = bus.we & full & ~pop & ~bus.flush;
    under = bus.re & ~av & ~bus.flush;
  end

  assign bus.full  = full;
  assign bus.afull = int'(free) <= AFULL_TH;
  assign bus.av    = av;
  assign bus.cnt   = cnt;
  assign bus.ovf   = ovf;
  assign bus.dout  = byp ? bus.din : mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (drop | under) ovf <= 1'b1;
      if (bus.flush) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (do_wr) wptr <= wptr + 1'b1;
        if (do_rd) rptr <= rptr + 1'b1;
        case ({do_wr, do_rd})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Storage is deliberately left out of reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= bus.din;
  end
endmodule

// File: tb/tb_pipe_link.sv
// Randomized plus directed scoreboard bench for pipe_link (DATA_L=8, ADDR_L=2, AFULL_TH=2).
module tb_pipe_link;
  localparam int DL = 8, AL = 2, TH = 2, DEPTH = 4;
`ifdef PIPE_LINK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic          full, afull, av, ovf;
    logic [AL:0]   cnt;
    logic [DL-1:0] head;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_link_if #(.DATA_L(DL), .ADDR_L(AL)) bus ();
  pipe_link #(.DATA_L(DL), .ADDR_L(AL), .AFULL_TH(TH)) dut (.clk(clk), .rst(rst), .bus(bus));

  st_t           st_q[$];
  logic [DL-1:0] dq[$];
  logic [DL-1:0] mq[$];
  bit            movf;
  int            n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle status record, plus popped data whenever the DUT pops.
  always @(negedge clk) begin
    st_t e;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      chk("full",  32'(bus.full),  32'(e.full));
      chk("afull", 32'(bus.afull), 32'(e.afull));
      chk("av",    32'(bus.av),    32'(e.av));
      chk("ovf",   32'(bus.ovf),   32'(e.ovf));
      chk("cnt",   32'(bus.cnt),   32'(e.cnt));
      if (e.av) chk("head", 32'(bus.dout), 32'(e.head));
    end
    if (rst && !bus.flush && bus.av && bus.re) begin
      if (dq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_data: unexpected pop dout=%0h, none expected", bus.dout);
      end else begin
        chk("pop_data", 32'(bus.dout), 32'(dq.pop_front()));
      end
    end
  end

  // One clock of stimulus; the reference model is a plain queue of stored words.
  task automatic step(input bit f, input bit w, input bit r, input logic [DL-1:0] d);
    st_t e;
    int  n;
    bit  byp, av, pop;
    @(posedge clk);
    #1;
    bus.flush = f; bus.we = w; bus.re = r; bus.din = d;
    n      = mq.size();
    byp    = BYP && n == 0 && !f && w;
    av     = (n != 0) || byp;
    e.full  = (n == DEPTH);
    e.afull = ((DEPTH - n) <= TH);
    e.av    = av;
    e.ovf   = movf;
    e.cnt   = 3'(n);
    e.head  = byp ? d : (n != 0 ? mq[0] : '0);
    st_q.push_back(e);
    if (f) begin
      mq.delete();
    end else begin
      pop = r && av;
      if (r && !av) movf = 1'b1;
      if (byp && r) begin
        dq.push_back(d);
      end else begin
        if (pop) dq.push_back(mq.pop_front());
        if (w) begin
          if (mq.size() < DEPTH) mq.push_back(d);
          else movf = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.flush = 0; bus.we = 0; bus.re = 0; bus.din = '0;
    mq.delete();
    movf = 1'b0;
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    rst = 1'b1;
  endtask

  initial begin
    logic [DL-1:0] v;
    bus.flush = 0; bus.we = 0; bus.re = 0; bus.din = '0;
    movf = 1'b0;
    do_reset();

    // Fill, drain, then full with simultaneous write and pop.
    step(0, 1, 0, 8'h11); step(0, 1, 0, 8'h22); step(0, 1, 0, 8'h33); step(0, 1, 0, 8'h44);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h11); step(0, 1, 0, 8'h22); step(0, 1, 0, 8'h33); step(0, 1, 0, 8'h44);
    step(0, 1, 1, 8'h55);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Overflow at full, then underflow after reset.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'hA0 + i));
    step(0, 1, 0, 8'h99);
    step(0, 0, 0, 8'h00);
    do_reset();
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    do_reset();

    // Flush beats a same-cycle write and pop.
    step(0, 1, 0, 8'h01); step(0, 1, 0, 8'h02); step(0, 1, 0, 8'h03);
    step(1, 1, 1, 8'hAB);
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h66);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Pointer wrap with alternating write/pop pairs.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 8'(8'hC0 + i));
      step(0, 0, 1, 8'h00);
    end

    // Empty write with same-cycle pop (bypass path when compiled in).
    step(0, 1, 1, 8'h77);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Random traffic with occasional flushes and mid-operation resets.
    for (int i = 0; i < 600; i++) begin
      if (i % 200 == 199) do_reset();
      v = 8'($urandom);
      step($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0 ? ($urandom_range(0, 1) == 1) : 1'b0, v);
    end

    step(0, 0, 0, 8'h00);
    @(negedge clk);
    #1;
    chk("pending_pops", 32'(dq.size()), 32'd0);
    chk("pending_status", 32'(st_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
